sumador_serie: RTL and testbench

- Parametrised multi-cycle adder/subtractor; successor of the single-bit full adder cell.
- Processes DIGIT bits per clock over an N-bit operand pair, with a start/ready/done handshake.
- Provides registered result, carry-out, signed-overflow and zero flags.
- Used by the CPU datapath where a narrow, area-cheap adder is preferred over a full-width combinational one.

---
 rtl/sumador_serie_if.sv | 27 ++
 rtl/sumador_serie.sv | 132 +++++++++++++
 tb/tb_sumador_serie.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sumador_serie_if.sv
// Operand/result bundle for the serial adder: start/ready/done handshake plus
// captured operands and registered result flags.
interface sumador_serie_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, cin, sub,
        input  ready, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, a, b, cin, sub,
        output ready, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/sumador_serie.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits of the operand pair per
// clock, LSB first, and presents result/cout/ovf/zero when done pulses.
module sumador_serie #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic            clk,
    input logic            rst,
    sumador_serie_if.slave bus
);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("sumador_serie: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    localparam int NSTEPS = WIDTH / DIGIT;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int DW     = DIGIT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_cmsb;
    logic             last_step;

    // Carry into the digit's top bit falls out of sum ^ a ^ b at that position,
    // which on the last digit is the carry into bit WIDTH-1.
    always_comb begin
        {dig_cout, dig_sum} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(carry_q);
        dig_cmsb            = dig_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        last_step           = (cnt_q == CW'(NSTEPS - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? ~bus.cin : bus.cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CW'(1);
                if (last_step) begin
                    cnt_d    = '0;
                    result_d = sum_d;
                    cout_d   = dig_cout;
                    ovf_d    = dig_cmsb ^ dig_cout;
                    zero_d   = (sum_d == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.ready  = (state_q == IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Scoreboard bench for sumador_serie: dut0 is WIDTH=8/DIGIT=1, dut1 is WIDTH=8/DIGIT=4.
module tb_sumador_serie;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sumador_serie_if #(.WIDTH(W)) bus0 ();
    sumador_serie_if #(.WIDTH(W)) bus1 ();

    sumador_serie #(.WIDTH(W), .DIGIT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sumador_serie #(.WIDTH(W), .DIGIT(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic         st [2];
    logic [W-1:0] av [2];
    logic [W-1:0] bv [2];
    logic         ci [2];
    logic         sb [2];

    assign bus0.start = st[0];
    assign bus0.a     = av[0];
    assign bus0.b     = bv[0];
    assign bus0.cin   = ci[0];
    assign bus0.sub   = sb[0];
    assign bus1.start = st[1];
    assign bus1.a     = av[1];
    assign bus1.b     = bv[1];
    assign bus1.cin   = ci[1];
    assign bus1.sub   = sb[1];

    logic         rdy [2];
    logic         dn  [2];
    logic [W-1:0] res [2];
    logic         co  [2];
    logic         ov  [2];
    logic         zr  [2];

    assign rdy[0] = bus0.ready;
    assign dn[0]  = bus0.done;
    assign res[0] = bus0.result;
    assign co[0]  = bus0.cout;
    assign ov[0]  = bus0.ovf;
    assign zr[0]  = bus0.zero;
    assign rdy[1] = bus1.ready;
    assign dn[1]  = bus1.done;
    assign res[1] = bus1.result;
    assign co[1]  = bus1.cout;
    assign ov[1]  = bus1.ovf;
    assign zr[1]  = bus1.zero;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           start_cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic int nsteps(input int unsigned i);
        return (i == 0) ? 8 : 2;
    endfunction

    task automatic chk(input string name, input int unsigned idx,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, idx, act, req, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic rst_prev = 1'b0;
    bit   started  = 1'b0;
    exp_t hold [2];
    int   rlow [2] = '{0, 0};
    int   dcnt [2] = '{0, 0};
    exp_t e;
    bit   qempty;

    always @(negedge clk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (rst_prev) begin
                chk("rst_ready", i, 32'(rdy[i]), 1);
                chk("rst_done", i, 32'(dn[i]), 0);
                chk("rst_result", i, 32'(res[i]), 0);
                chk("rst_flags", i, 32'({co[i], ov[i], zr[i]}), 0);
                hold[i].res  = '0;
                hold[i].cout = 1'b0;
                hold[i].ovf  = 1'b0;
                hold[i].zero = 1'b0;
                rlow[i] = 0;
                dcnt[i] = 0;
            end else if (started) begin
                if (dn[i]) begin
                    dcnt[i]++;
                    if (dcnt[i] == 1) begin
                        qempty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
                        if (qempty) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done dut%0d: got done=1, expected no operation pending (t=%0t)", i, $time);
                        end else begin
                            if (i == 0) e = q0.pop_front();
                            else        e = q1.pop_front();
                            chk("result", i, 32'(res[i]), 32'(e.res));
                            chk("cout", i, 32'(co[i]), 32'(e.cout));
                            chk("ovf", i, 32'(ov[i]), 32'(e.ovf));
                            chk("zero", i, 32'(zr[i]), 32'(e.zero));
                            chk("latency", i, 32'(cyc - e.start_cyc), 32'(nsteps(i) + 1));
                            hold[i] = e;
                        end
                    end
                end else begin
                    if (dcnt[i] > 0) begin
                        chk("done_width", i, 32'(dcnt[i]), 1);
                        dcnt[i] = 0;
                    end
                    chk("hold_result", i, 32'(res[i]), 32'(hold[i].res));
                    chk("hold_flags", i, 32'({co[i], ov[i], zr[i]}),
                        32'({hold[i].cout, hold[i].ovf, hold[i].zero}));
                end
                if (!rdy[i]) begin
                    rlow[i]++;
                end else if (rlow[i] > 0) begin
                    chk("ready_low", i, 32'(rlow[i]), 32'(nsteps(i) + 1));
                    rlow[i] = 0;
                end
            end
        end
        if (rst_prev) started = 1'b1;
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned i, input logic [W-1:0] r,
                        input logic c, input logic o, input logic z);
        exp_t x;
        x.res       = r;
        x.cout      = c;
        x.ovf       = o;
        x.zero      = z;
        x.start_cyc = cyc;
        if (i == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic issue(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        st[i] = 1'b1;
        av[i] = a;
        bv[i] = b;
        ci[i] = cin;
        sb[i] = sub;
    endtask

    task automatic wait_idle(input int unsigned i);
        bit empty;
        for (int unsigned n = 0; n < 40; n++) begin
            tick();
            empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty && rdy[i]) return;
        end
        $display("FAIL timeout dut%0d: got no done within 40 cycles, expected done", i);
        $fatal(1, "operation did not complete");
    endtask

    // Operands are scrambled right after acceptance; they must not matter.
    task automatic run_op(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W-1:0] r,
                          input logic c, input logic o, input logic z);
        issue(i, a, b, cin, sub);
        push(i, r, c, o, z);
        tick();
        st[i] = 1'b0;
        av[i] = ~a;
        bv[i] = a ^ b;
        ci[i] = ~cin;
        sb[i] = ~sub;
        wait_idle(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            st[i] = 1'b0;
            av[i] = '0;
            bv[i] = '0;
            ci[i] = 1'b0;
            sb[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        tick();

        // WIDTH=8, DIGIT=1 arithmetic
        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op(0, 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op(0, 8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0, 1'b0);

        // start held high: only the k=0 and k=10 operands land on ready edges
        for (int unsigned k = 0; k <= 10; k++) begin
            if (k == 0) begin
                issue(0, 8'h22, 8'h11, 1'b0, 1'b0);
                push(0, 8'h33, 1'b0, 1'b0, 1'b0);
            end else if (k == 10) begin
                issue(0, 8'h40, 8'h40, 1'b0, 1'b0);
                push(0, 8'h80, 1'b0, 1'b1, 1'b0);
            end else begin
                issue(0, 8'(k * 37 + 5), 8'(k * 91), k[0], k[1]);
            end
            tick();
        end
        st[0] = 1'b0;
        wait_idle(0);

        // reset in the middle of CALC, with start asserted alongside rst
        issue(0, 8'h55, 8'h22, 1'b0, 1'b0);
        tick();
        st[0] = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        issue(0, 8'h01, 8'h01, 1'b0, 1'b0);
        tick();
        rst   = 1'b0;
        st[0] = 1'b0;
        tick();
        tick();
        run_op(0, 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);

        // WIDTH=8, DIGIT=4
        run_op(1, 8'h9C, 8'h6B, 1'b1, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0);
        run_op(1, 8'h30, 8'h50, 1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
        run_op(1, 8'h7F, 8'h7F, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0);
        run_op(1, 8'h01, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
